// File: rtl/axis_b_rr_arbiter.sv
// Round-robin arbiter merging N_SRC 2-bit response streams onto one
// registered output stream. Each output beat carries the index of the
// source it was taken from. The output register doubles as one pipeline
// stage and reloads in the same cycle it is popped, so throughput is one
// beat per cycle under continuous ready.
module axis_b_rr_arbiter #(
    parameter  int N_SRC    = 4,
    localparam int SRC_BITS = $clog2(N_SRC)
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [N_SRC-1:0]          s_axis_tvalid,
    output logic [N_SRC-1:0]          s_axis_tready,
    input  logic [N_SRC-1:0][1:0]     s_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [1:0]                m_axis_tuser,
    output logic [SRC_BITS-1:0]       m_axis_tid
);

    localparam logic [SRC_BITS:0]   NSRC_W = (SRC_BITS+1)'(N_SRC);
    localparam logic [SRC_BITS-1:0] LAST   = SRC_BITS'(N_SRC - 1);

    // Output register and round-robin pointer
    logic                m_valid_q, m_valid_d;
    logic [1:0]          m_user_q,  m_user_d;
    logic [SRC_BITS-1:0] m_tid_q,   m_tid_d;
    logic [SRC_BITS-1:0] rr_ptr_q,  rr_ptr_d;

    logic                ld;
    logic                any_v;
    logic                xfer;
    logic                found;
    logic [SRC_BITS-1:0] gnt;
    logic [SRC_BITS:0]   cand;

    // The register can accept a new beat when empty or being popped.
    assign ld    = ~m_valid_q | m_axis_tready;
    assign any_v = |s_axis_tvalid;
    // Readies are forced low while reset is held, even though ld is 1 then.
    assign xfer  = ld & any_v & ~areset;

    // Cyclic priority search starting at rr_ptr: first valid source wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, rr_ptr_q} + (SRC_BITS+1)'(k);
            if (cand >= NSRC_W) begin
                cand = cand - NSRC_W;
            end
            if (!found && s_axis_tvalid[cand[SRC_BITS-1:0]]) begin
                gnt   = cand[SRC_BITS-1:0];
                found = 1'b1;
            end
        end
    end

    // One-hot ready to the granted source only when the output can load.
    always_comb begin
        s_axis_tready = '0;
        if (xfer) begin
            s_axis_tready[gnt] = 1'b1;
        end
    end

    // Next state: load the granted beat, go empty when idle, hold when stalled.
    always_comb begin
        m_valid_d = m_valid_q;
        m_user_d  = m_user_q;
        m_tid_d   = m_tid_q;
        rr_ptr_d  = rr_ptr_q;
        if (ld) begin
            if (any_v) begin
                m_valid_d = 1'b1;
                m_user_d  = s_axis_tuser[gnt];
                m_tid_d   = gnt;
                // Pointer moves past the winner so it drops to lowest priority.
                rr_ptr_d  = (gnt == LAST) ? '0 : gnt + SRC_BITS'(1);
            end else begin
                m_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any held beat, even mid-handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_valid_q <= 1'b0;
            m_user_q  <= '0;
            m_tid_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_user_q  <= m_user_d;
            m_tid_q   <= m_tid_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tid    = m_tid_q;

endmodule

// File: tb/tb_axis_b_rr_arbiter.sv
// Bench for axis_b_rr_arbiter: directed stimulus, a queue-free behavioural
// model of the arbiter checked every cycle, and literal expectations per test.
module tb_axis_b_rr_arbiter;

    localparam int N = 4;

    logic             aclk = 1'b0;
    logic             areset = 1'b0;
    logic [N-1:0]     s_axis_tvalid = '0;
    logic [N-1:0]     s_axis_tready;
    logic [N-1:0][1:0] s_axis_tuser = '0;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic [1:0]       m_axis_tuser;
    logic [1:0]       m_axis_tid;

    int errs = 0;
    int checks = 0;

    axis_b_rr_arbiter #(.N_SRC(N)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tid    (m_axis_tid)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       mv = 1'b0;
    logic [1:0] mu = '0;
    int         mt = 0;
    int         mp = 0;

    // First valid source when scanning cyclically from pointer p.
    function automatic int mgrant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            mv <= 1'b0; mu <= '0; mt <= 0; mp <= 0;
        end else if (!mv || m_axis_tready) begin
            if (mgrant(s_axis_tvalid, mp) >= 0) begin
                mv <= 1'b1;
                mu <= s_axis_tuser[mgrant(s_axis_tvalid, mp)];
                mt <= mgrant(s_axis_tvalid, mp);
                mp <= (mgrant(s_axis_tvalid, mp) + 1) % N;
            end else begin
                mv <= 1'b0;
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge aclk) begin
        int g;
        int exp_rdy;
        g = mgrant(s_axis_tvalid, mp);
        exp_rdy = 0;
        if (!areset && (!mv || m_axis_tready) && g >= 0) exp_rdy = 1 << g;
        chk("mdl_tready", int'(s_axis_tready), exp_rdy);
        chk("mdl_onehot0", int'($onehot0(s_axis_tready)), 1);
        chk("mdl_tvalid", int'(m_axis_tvalid), int'(mv));
        chk("mdl_rr_ptr", int'(dut.rr_ptr_q), mp);
        if (mv || areset) begin
            chk("mdl_tuser", int'(m_axis_tuser), int'(mu));
            chk("mdl_tid", int'(m_axis_tid), mt);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 areset = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", int'(m_axis_tvalid), 0);
        chk("rst_tid", int'(m_axis_tid), 0);
        chk("rst_tuser", int'(m_axis_tuser), 0);
        chk("rst_tready", int'(s_axis_tready), 0);
        areset = 1'b0;
        repeat (2) tick();
        chk("idle_tvalid", int'(m_axis_tvalid), 0);

        // full contention, payload = source index
        for (int i = 0; i < N; i++) s_axis_tuser[i] = 2'(i);
        s_axis_tvalid = 4'hF;
        m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr_tvalid", int'(m_axis_tvalid), 1);
            chk("rr_tid", int'(m_axis_tid), k % 4);
            chk("rr_tuser", int'(m_axis_tuser), k % 4);
        end

        // drain, then backpressure with sources 1 and 3
        s_axis_tvalid = '0;
        tick();
        chk("drain_tvalid", int'(m_axis_tvalid), 0);
        s_axis_tvalid = 4'b1010;
        m_axis_tready = 1'b0;
        tick();
        chk("bp_first_tid", int'(m_axis_tid), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_tvalid", int'(m_axis_tvalid), 1);
            chk("bp_hold_tid", int'(m_axis_tid), 1);
            chk("bp_hold_tuser", int'(m_axis_tuser), 1);
            chk("bp_tready", int'(s_axis_tready), 0);
        end
        m_axis_tready = 1'b1;
        tick(); chk("bp_rel_tid0", int'(m_axis_tid), 3);
        tick(); chk("bp_rel_tid1", int'(m_axis_tid), 1);
        tick(); chk("bp_rel_tid2", int'(m_axis_tid), 3);

        // pointer skip and wrap
        s_axis_tvalid = 4'b0100;
        tick();
        chk("skip_tid", int'(m_axis_tid), 2);
        chk("skip_ptr", int'(dut.rr_ptr_q), 3);
        s_axis_tvalid = 4'b1001;
        tick(); chk("wrap_tid_a", int'(m_axis_tid), 3);
        tick(); chk("wrap_tid_b", int'(m_axis_tid), 0);

        // single streamer
        s_axis_tvalid = 4'b0001;
        s_axis_tuser[0] = 2'b10;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("stream_tvalid", int'(m_axis_tvalid), 1);
            chk("stream_tid", int'(m_axis_tid), 0);
            chk("stream_tuser", int'(m_axis_tuser), 2);
        end

        // asynchronous reset while a beat is stalled
        s_axis_tvalid = 4'hF;
        m_axis_tready = 1'b0;
        tick();
        chk("arst_pre_tvalid", int'(m_axis_tvalid), 1);
        #2 areset = 1'b1;
        #1;
        chk("arst_tvalid", int'(m_axis_tvalid), 0);
        chk("arst_ptr", int'(dut.rr_ptr_q), 0);
        chk("arst_tready", int'(s_axis_tready), 0);
        tick();
        tick();
        areset = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("arst_first_tvalid", int'(m_axis_tvalid), 1);
        chk("arst_first_tid", int'(m_axis_tid), 0);
        tick();
        chk("arst_second_tid", int'(m_axis_tid), 1);

        s_axis_tvalid = '0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
